// File: rtl/spell_shared_ram_ctrl_pkg.sv
// Shared types and constants for the spell shared-RAM controller.
// Holds FSM state encodings, port identifiers, ack latencies and the
// registered macro command bundle, plus the 2-way round-robin pick.
package spell_shared_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_RWAIT = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Cycles from the first IDLE cycle a request is seen to its ack.
  localparam int WRITE_ACK_LATENCY = 2;
  localparam int READ_ACK_LATENCY  = 3;

  // Registered drive for the OpenRAM control/data pins (address kept
  // separately because its width is a module parameter).
  typedef struct packed {
    logic        csb;
    logic        web;
    logic [3:0]  wmask;
    logic [31:0] din;
  } sram_cmd_t;

  // Single requester wins outright; on a tie the port that did not own
  // the previous grant wins.
  function automatic logic rr_pick(input logic req_a, input logic req_b,
                                   input logic last);
    logic pick;
    if (req_a && req_b) pick = ~last;
    else if (req_b)     pick = PORT_B;
    else                pick = PORT_A;
    return pick;
  endfunction

endpackage

// File: rtl/spell_shared_ram_ctrl.sv
// Purpose : arbitrates the spell rambus master (A) and the host Wishbone (B)
//           onto one OpenRAM 1RW port, one access in flight, round-robin.
// Latency : write ack 2 cycles, read ack 3 cycles after the request is seen
//           in IDLE; the losing port waits with ack low (no other backpressure).
// Ports   : clock/reset; a_* and b_* Wishbone slaves; sram_* macro pins;
//           grant_o shows the port of the current or last transaction.
module spell_shared_ram_ctrl
  import spell_shared_ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int HOST_BASE_LSB = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  // port A: spell rambus master
  input  logic                  a_stb_i,
  input  logic                  a_cyc_i,
  input  logic                  a_we_i,
  input  logic [3:0]            a_sel_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [31:0]           a_dat_i,
  output logic                  a_ack_o,
  output logic [31:0]           a_dat_o,
  // port B: management SoC host
  input  logic                  b_stb_i,
  input  logic                  b_cyc_i,
  input  logic                  b_we_i,
  input  logic [3:0]            b_sel_i,
  input  logic [31:0]           b_addr_i,
  input  logic [31:0]           b_dat_i,
  output logic                  b_ack_o,
  output logic [31:0]           b_dat_o,
  // OpenRAM 1RW port
  output logic                  sram_clk0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  input  logic [31:0]           sram_dout0,
  output logic                  grant_o
);

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;       // current / last granted port
  logic                  we_q, we_d;         // latched direction
  sram_cmd_t             cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [31:0]           a_dat_q, a_dat_d, b_dat_q, b_dat_d;

  logic                  req_a, req_b, pick;
  logic                  pick_we;
  logic [3:0]            pick_sel;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [31:0]           pick_dat;
  logic [ADDR_WIDTH-1:0] b_word;
  logic                  granted_cyc;
  logic                  b_addr_unused;

  assign req_a  = a_stb_i & a_cyc_i;
  assign req_b  = b_stb_i & b_cyc_i;
  assign b_word = b_addr_i[HOST_BASE_LSB+ADDR_WIDTH-1:HOST_BASE_LSB];
  // Bits outside the word slice are decoded upstream.
  assign b_addr_unused = ^b_addr_i;

  assign pick      = rr_pick(req_a, req_b, gnt_q);
  assign pick_we   = (pick == PORT_B) ? b_we_i  : a_we_i;
  assign pick_sel  = (pick == PORT_B) ? b_sel_i : a_sel_i;
  assign pick_addr = (pick == PORT_B) ? b_word  : a_addr_i;
  assign pick_dat  = (pick == PORT_B) ? b_dat_i : a_dat_i;

  // A master that dropped cyc mid-transfer has abandoned it: no ack.
  assign granted_cyc = (gnt_q == PORT_B) ? b_cyc_i : a_cyc_i;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    cmd_d     = '{csb: 1'b1, web: 1'b1, wmask: 4'h0, din: cmd_q.din};
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_dat_d   = a_dat_q;
    b_dat_d   = b_dat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          gnt_d   = pick;
          we_d    = pick_we;
          addr_d  = pick_addr;
          // The command registers are loaded here so the macro sees the
          // access during the CMD cycle. A write with no bytes selected
          // keeps the macro deselected but still completes.
          cmd_d.csb   = pick_we && (pick_sel == 4'h0);
          cmd_d.web   = ~pick_we;
          cmd_d.wmask = pick_we ? pick_sel : 4'h0;
          cmd_d.din   = pick_we ? pick_dat : cmd_q.din;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (we_q) begin
          a_ack_d = (gnt_q == PORT_A) && granted_cyc;
          b_ack_d = (gnt_q == PORT_B) && granted_cyc;
          state_d = ST_ACK;
        end else begin
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        // Macro output is valid the cycle after its capture edge.
        if (gnt_q == PORT_B) b_dat_d = sram_dout0;
        else                 a_dat_d = sram_dout0;
        a_ack_d = (gnt_q == PORT_A) && granted_cyc;
        b_ack_d = (gnt_q == PORT_B) && granted_cyc;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= PORT_B;  // so A wins the first tie
      we_q    <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '{csb: 1'b1, web: 1'b1, wmask: 4'h0, din: 32'h0};
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_dat_q <= 32'h0;
      b_dat_q <= 32'h0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      a_dat_q <= a_dat_d;
      b_dat_q <= b_dat_d;
    end
  end

  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign a_dat_o     = a_dat_q;
  assign b_dat_o     = b_dat_q;
  assign sram_clk0   = clock;
  assign sram_csb0   = cmd_q.csb;
  assign sram_web0   = cmd_q.web;
  assign sram_wmask0 = cmd_q.wmask;
  assign sram_addr0  = addr_q;
  assign sram_din0   = cmd_q.din;
  assign grant_o     = gnt_q;

endmodule

// File: tb/tb_spell_shared_ram_ctrl.sv
// Directed bench for spell_shared_ram_ctrl with a behavioural 1-cycle
// OpenRAM model; read data is checked through per-port scoreboards.
module tb_spell_shared_ram_ctrl;
  import spell_shared_ram_ctrl_pkg::*;

  logic        clock, reset;
  logic        a_stb_i, a_cyc_i, a_we_i;
  logic [3:0]  a_sel_i;
  logic [7:0]  a_addr_i;
  logic [31:0] a_dat_i;
  logic        a_ack_o;
  logic [31:0] a_dat_o;
  logic        b_stb_i, b_cyc_i, b_we_i;
  logic [3:0]  b_sel_i;
  logic [31:0] b_addr_i, b_dat_i;
  logic        b_ack_o;
  logic [31:0] b_dat_o;
  logic        sram_clk0, sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  logic        grant_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] sram_mem [0:255];
  logic [31:0] exp_mem  [0:255];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];

  spell_shared_ram_ctrl #(.ADDR_WIDTH(8), .HOST_BASE_LSB(2)) dut (
    .clock(clock), .reset(reset),
    .a_stb_i(a_stb_i), .a_cyc_i(a_cyc_i), .a_we_i(a_we_i), .a_sel_i(a_sel_i),
    .a_addr_i(a_addr_i), .a_dat_i(a_dat_i), .a_ack_o(a_ack_o), .a_dat_o(a_dat_o),
    .b_stb_i(b_stb_i), .b_cyc_i(b_cyc_i), .b_we_i(b_we_i), .b_sel_i(b_sel_i),
    .b_addr_i(b_addr_i), .b_dat_i(b_dat_i), .b_ack_o(b_ack_o), .b_dat_o(b_dat_o),
    .sram_clk0(sram_clk0), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_dout0(sram_dout0), .grant_o(grant_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural OpenRAM: captures on the rising edge, read data valid after it.
  always @(posedge sram_clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) sram_mem[sram_addr0][8*i +: 8] <= sram_din0[8*i +: 8];
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Both acks must never be high together.
  always @(negedge clock) begin
    if (!reset) begin
      n_assert++;
      assert (!(a_ack_o && b_ack_o)) else begin
        n_fail++;
        $error("FAIL ack_exclusive: observed a=%b b=%b expected not both", a_ack_o, b_ack_o);
      end
    end
  end

  task automatic drive(input logic port, input logic we, input logic [3:0] sel,
                       input logic [7:0] waddr, input logic [31:0] dat);
    if (port == PORT_A) begin
      a_stb_i = 1; a_cyc_i = 1; a_we_i = we; a_sel_i = sel; a_addr_i = waddr; a_dat_i = dat;
    end else begin
      b_stb_i = 1; b_cyc_i = 1; b_we_i = we; b_sel_i = sel;
      b_addr_i = 32'h3000_0000 | ({24'h0, waddr} << 2); b_dat_i = dat;
    end
  endtask

  task automatic drop(input logic port);
    if (port == PORT_A) begin a_stb_i = 0; a_cyc_i = 0; end
    else begin b_stb_i = 0; b_cyc_i = 0; end
  endtask

  task automatic model_write(input logic [3:0] sel, input logic [7:0] waddr, input logic [31:0] dat);
    for (int i = 0; i < 4; i++)
      if (sel[i]) exp_mem[waddr][8*i +: 8] = dat[8*i +: 8];
  endtask

  // One complete transfer, called at a negedge with the bus idle.
  task automatic xfer(input string tag, input logic port, input logic we,
                      input logic [3:0] sel, input logic [7:0] waddr, input logic [31:0] dat);
    int lat;
    logic ack, oack;
    logic [31:0] exp_d;
    drive(port, we, sel, waddr, dat);
    if (we) model_write(sel, waddr, dat);
    else if (port == PORT_A) q_a.push_back(exp_mem[waddr]);
    else q_b.push_back(exp_mem[waddr]);
    @(negedge clock);
    chk({tag, ".csb0"},  {31'h0, sram_csb0}, {31'h0, (we && sel == 4'h0)});
    chk({tag, ".web0"},  {31'h0, sram_web0}, {31'h0, ~we});
    chk({tag, ".wmask"}, {28'h0, sram_wmask0}, we ? {28'h0, sel} : 32'h0);
    chk({tag, ".addr0"}, {24'h0, sram_addr0}, {24'h0, waddr});
    if (we) chk({tag, ".din0"}, sram_din0, dat);
    lat = 1;
    ack = (port == PORT_A) ? a_ack_o : b_ack_o;
    while (!ack && lat < 8) begin
      @(negedge clock);
      lat++;
      ack  = (port == PORT_A) ? a_ack_o : b_ack_o;
      oack = (port == PORT_A) ? b_ack_o : a_ack_o;
      chk({tag, ".other_ack"}, {31'h0, oack}, 32'h0);
    end
    chk({tag, ".latency"}, lat, we ? 32'd2 : 32'd3);
    chk({tag, ".grant"}, {31'h0, grant_o}, {31'h0, port});
    if (!we && ack) begin
      if (port == PORT_A) begin exp_d = q_a.pop_front(); chk({tag, ".dat"}, a_dat_o, exp_d); end
      else begin exp_d = q_b.pop_front(); chk({tag, ".dat"}, b_dat_o, exp_d); end
    end
    drop(port);
    @(negedge clock);
    ack = (port == PORT_A) ? a_ack_o : b_ack_o;
    chk({tag, ".ack_pulse"}, {31'h0, ack}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
  endtask

  initial begin
    logic       order [$];
    int         a_left, b_left, guard;
    logic       a_re, b_re;
    logic [31:0] d;

    reset = 1;
    a_stb_i = 0; a_cyc_i = 0; a_we_i = 0; a_sel_i = 0; a_addr_i = 0; a_dat_i = 0;
    b_stb_i = 0; b_cyc_i = 0; b_we_i = 0; b_sel_i = 0; b_addr_i = 0; b_dat_i = 0;
    repeat (3) @(negedge clock);

    // Reset values
    chk("rst.a_ack", {31'h0, a_ack_o}, 32'h0);
    chk("rst.b_ack", {31'h0, b_ack_o}, 32'h0);
    chk("rst.a_dat", a_dat_o, 32'h0);
    chk("rst.b_dat", b_dat_o, 32'h0);
    chk("rst.csb0", {31'h0, sram_csb0}, 32'h1);
    chk("rst.web0", {31'h0, sram_web0}, 32'h1);
    chk("rst.wmask", {28'h0, sram_wmask0}, 32'h0);
    chk("rst.addr0", {24'h0, sram_addr0}, 32'h0);
    chk("rst.din0", sram_din0, 32'h0);
    chk("rst.grant", {31'h0, grant_o}, 32'h1);
    chk("rst.state", {30'h0, dut.state_q}, {30'h0, ST_IDLE});
    reset = 0;
    @(negedge clock);

    // Basic write on A, read back through B's byte address, partial write.
    xfer("a_wr10", PORT_A, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF);
    xfer("b_rd10", PORT_B, 1'b0, 4'hF, 8'h10, 32'h0);
    xfer("b_wr05", PORT_B, 1'b1, 4'hF, 8'h05, 32'h1122_3344);
    xfer("a_wr05p", PORT_A, 1'b1, 4'b0001, 8'h05, 32'h0000_00AA);
    xfer("a_rd05", PORT_A, 1'b0, 4'hF, 8'h05, 32'h0);
    xfer("a_wr05z", PORT_A, 1'b1, 4'b0000, 8'h05, 32'hFFFF_FFFF);
    xfer("b_rd05", PORT_B, 1'b0, 4'hF, 8'h05, 32'h0);
    xfer("b_wr20h", PORT_B, 1'b1, 4'b1100, 8'h20, 32'h5566_7788);
    xfer("a_rd10", PORT_A, 1'b0, 4'hF, 8'h10, 32'h0);

    // Contention straight after reset: A first, then strict alternation.
    do_reset();
    q_a.push_back(exp_mem[8'h10]); q_a.push_back(exp_mem[8'h10]);
    q_b.push_back(exp_mem[8'h05]); q_b.push_back(exp_mem[8'h05]);
    drive(PORT_A, 1'b0, 4'hF, 8'h10, 32'h0);
    drive(PORT_B, 1'b0, 4'hF, 8'h05, 32'h0);
    a_left = 2; b_left = 2; a_re = 0; b_re = 0; guard = 0;
    while ((a_left > 0 || b_left > 0) && guard < 60) begin
      @(negedge clock);
      guard++;
      if (a_re) begin a_stb_i = 1; a_cyc_i = 1; a_re = 0; end
      if (b_re) begin b_stb_i = 1; b_cyc_i = 1; b_re = 0; end
      if (a_ack_o) begin
        order.push_back(PORT_A);
        chk("cont.a_grant", {31'h0, grant_o}, 32'h0);
        d = q_a.pop_front(); chk("cont.a_dat", a_dat_o, d);
        drop(PORT_A); a_left--; a_re = (a_left > 0);
      end
      if (b_ack_o) begin
        order.push_back(PORT_B);
        chk("cont.b_grant", {31'h0, grant_o}, 32'h1);
        d = q_b.pop_front(); chk("cont.b_dat", b_dat_o, d);
        drop(PORT_B); b_left--; b_re = (b_left > 0);
      end
    end
    chk("cont.count", order.size(), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("cont.order%0d", i), {31'h0, order[i]}, {31'h0, i[0]});
    @(negedge clock);

    // Abort: A drops cyc during RWAIT, no ack, then B served normally.
    drive(PORT_A, 1'b0, 4'hF, 8'h10, 32'h0);
    @(negedge clock);
    chk("abort.a_ack_cmd", {31'h0, a_ack_o}, 32'h0);
    @(negedge clock);
    drop(PORT_A);
    chk("abort.a_ack_rwait", {31'h0, a_ack_o}, 32'h0);
    @(negedge clock);
    chk("abort.a_ack_ack", {31'h0, a_ack_o}, 32'h0);
    @(negedge clock);
    chk("abort.a_ack_idle", {31'h0, a_ack_o}, 32'h0);
    chk("abort.state", {30'h0, dut.state_q}, {30'h0, ST_IDLE});
    xfer("abort.b_rd05", PORT_B, 1'b0, 4'hF, 8'h05, 32'h0);

    // Reset during CMD of a B write: dropped, no ack.
    drive(PORT_B, 1'b1, 4'hF, 8'h30, 32'hCAFE_F00D);
    @(negedge clock);
    chk("rcmd.csb0_cmd", {31'h0, sram_csb0}, 32'h0);
    reset = 1;
    @(negedge clock);
    chk("rcmd.csb0", {31'h0, sram_csb0}, 32'h1);
    chk("rcmd.web0", {31'h0, sram_web0}, 32'h1);
    chk("rcmd.b_ack", {31'h0, b_ack_o}, 32'h0);
    chk("rcmd.grant", {31'h0, grant_o}, 32'h1);
    chk("rcmd.state", {30'h0, dut.state_q}, {30'h0, ST_IDLE});
    drop(PORT_B);
    reset = 0;
    repeat (3) begin
      @(negedge clock);
      chk("rcmd.b_ack_after", {31'h0, b_ack_o}, 32'h0);
    end
    chk("sb.q_a_empty", q_a.size(), 32'd0);
    chk("sb.q_b_empty", q_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
